ov7670_config_sequencer: RTL and testbench
==========================================

Name: ov7670_config_sequencer

Overview:
Single-clock controller that brings the OV7670 out of reset and walks a register table. It issues one SCCB write per table entry to the SCCB byte-write master through a req/ack handshake. When the table completes it asserts start_capture to arm the pixel capture path. It runs in the core-clock domain, sits between the top level and the SCCB master, and replaces the ad-hoc sequencing inside the camera controller.

Parameters:
SCCB_ID, 8'h42, OV7670 write device ID driven on sccb_id
NUM_REGS, 64, number of table entries walked (index 0..NUM_REGS-1)
RESET_HOLD_CYCLES, 25000, cycles ov7670_reset is held low (1 ms at 25 MHz)
BOOT_CYCLES, 75000, cycles waited after reset release before the first write (3 ms)
DELAY_UNIT, 25000, cycles per unit of a table delay entry (1 ms)
SETTLE_CYCLES, 250000, cycles waited after the last write before start_capture (10 ms)
MAX_RETRIES, 3, NACK retries per entry before error

Ports:
clk  in  1  core clock (25 MHz)
reset_n  in  1  asynchronous active-low reset
restart  in  1  1-cycle pulse; re-runs the table; honoured only in DONE or ERROR
sccb_req  out  1  write request; held until ack/nack
sccb_id  out  8  device ID (constant SCCB_ID)
sccb_addr  out  8  register address
sccb_data  out  8  register value
sccb_ack  in  1  1-cycle pulse: write completed, ACKed
sccb_nack  in  1  1-cycle pulse: write completed, NACKed
ov7670_reset  out  1  camera reset, active low
ov7670_pwrdn  out  1  camera power-down, active high; constant 0 after reset
start_capture  out  1  level; high in DONE only
busy  out  1  high in every state except DONE/ERROR
error  out  1  level; high in ERROR only
err_index  out  log2(NUM_REGS)  table index of the failing entry; valid while error

Behaviour:
- Reset values: ov7670_reset=0, ov7670_pwrdn=0, sccb_req=0, sccb_addr=0, sccb_data=0, start_capture=0, busy=1, error=0, err_index=0. State=RST_HOLD, index=0, counter=0, retries=0.
- All outputs are registered.
- Table entry is 16 bits {addr[15:8], data[7:0]}, read from the sub-ROM with 1-cycle latency.
- Entry addr 8'hFF is a delay entry: wait data*DELAY_UNIT cycles and issue no SCCB write. data=0 means zero wait (one FETCH-to-DELAY pass only).
- RST_HOLD: ov7670_reset=0 for RESET_HOLD_CYCLES, then go to BOOT.
- BOOT: ov7670_reset=1; wait BOOT_CYCLES, then go to FETCH.
- FETCH: present index to the ROM; go to DECODE next cycle.
- DECODE: if addr==8'hFF, load counter and go to DELAY. Otherwise latch sccb_addr/sccb_data, set sccb_req=1, go to WAIT.
- WAIT: sccb_req, sccb_addr and sccb_data are stable until a response.
  - ack: drop sccb_req in the same edge; retries=0; go to NEXT.
  - nack with retries<MAX_RETRIES: drop req, retries++, go to REISSUE. REISSUE re-asserts sccb_req one cycle later with the same fields.
  - nack with retries==MAX_RETRIES: drop req, err_index=index, go to ERROR.
  - ack and nack in the same cycle: treated as nack.
- DELAY: count down; at 0 go to NEXT.
- NEXT: if index==NUM_REGS-1, go to SETTLE. Otherwise index++ and go to FETCH. The index never wraps.
- SETTLE: wait SETTLE_CYCLES, then go to DONE.
- DONE: start_capture=1, busy=0. restart moves to FETCH with index=0 and start_capture=0 on the next edge. The camera is not reset again.
- ERROR: error=1, busy=0, start_capture stays 0. restart clears error and err_index and goes to RST_HOLD (full reset re-run).
- restart in any other state is ignored.
- Unsolicited ack/nack outside WAIT is ignored.
- Asynchronous reset mid-transaction:
  - sccb_req drops immediately and ov7670_reset goes low.
  - The SCCB master must abort on req falling; that rule is owned by the master.
- Counters are 20 bits minimum. Delay product data*DELAY_UNIT is computed at full width without truncation (8 + log2(DELAY_UNIT) bits).
- Minimum entry period: write entry = FETCH+DECODE+WAIT(>=1)+NEXT = 4 cycles plus master time.

Decomposition:
- Shared package ov7670_pkg holds:
  - state enum/localparams
  - DELAY_MARKER = 8'hFF
  - OV7670_WRITE_ID = 8'h42
  - entry field offsets
  - COM7 reset address 8'h12
- Sub-module ov7670_reg_rom (param NUM_REGS; in clk, index; out 16-bit entry, registered). It holds the register table so it can be swapped for a VGA/QVGA variant without touching the sequencer.

Test Plan:
Every scenario uses RESET_HOLD_CYCLES=4, BOOT_CYCLES=8, DELAY_UNIT=10, SETTLE_CYCLES=5, MAX_RETRIES=2, and a bench ROM with NUM_REGS=3 holding {12,80},{FF,02},{40,D0}.
1. Reset release → ov7670_reset low for exactly 4 cycles, then high. First sccb_req rises 8 cycles after release plus FETCH/DECODE, with addr=12, data=80, id=42.
2. Bench acks every write after 3 cycles → exactly 2 SCCB writes. 20 idle cycles between the ack of the first write and the FETCH of the third entry. start_capture rises 5 cycles after the last ack plus NEXT; busy=0.
3. Second write NACKed twice, then ACKed → three requests with addr=40/data=D0 and a 1-cycle gap between each. Final state is DONE; error=0.
4. Second write NACKed 3 times → error=1, err_index=2, start_capture=0, no further req. A restart pulse then re-runs from RST_HOLD with ov7670_reset low for 4 cycles.
5. Assert reset_n low while in WAIT → sccb_req=0 and ov7670_reset=0 asynchronously, before the next clk edge. All outputs return to their reset values.
6. restart in DONE → start_capture drops next edge and the table re-runs without an ov7670_reset pulse. A restart pulse during SETTLE is ignored and the run completes normally.

Source files
------------

// File: rtl/ov7670_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// ov7670_pkg : shared constants, table-entry layout and sequencer states
// Revision   : 1.0
// ----------------------------------------------------------------------------
package ov7670_pkg;

  localparam logic [7:0] DELAY_MARKER    = 8'hFF;
  localparam logic [7:0] OV7670_WRITE_ID = 8'h42;
  localparam logic [7:0] COM7_ADDR       = 8'h12;

  localparam int ENTRY_W        = 16;
  localparam int ENTRY_ADDR_LSB = 8;
  localparam int ENTRY_DATA_LSB = 0;

  typedef enum logic [3:0] {
    S_RST_HOLD = 4'd0,
    S_BOOT     = 4'd1,
    S_FETCH    = 4'd2,
    S_DECODE   = 4'd3,
    S_WAIT     = 4'd4,
    S_REISSUE  = 4'd5,
    S_DELAY    = 4'd6,
    S_NEXT     = 4'd7,
    S_SETTLE   = 4'd8,
    S_DONE     = 4'd9,
    S_ERROR    = 4'd10
  } seq_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ov7670_config_sequencer_if.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// ov7670_config_sequencer_if : req/ack byte-write channel to the SCCB master
// Revision                   : 1.0
// ----------------------------------------------------------------------------
interface ov7670_config_sequencer_if;
  logic       req;
  logic [7:0] id;
  logic [7:0] addr;
  logic [7:0] data;
  logic       ack;
  logic       nack;

  modport master (output req, id, addr, data, input ack, nack);
  modport slave  (input req, id, addr, data, output ack, nack);
endinterface
`default_nettype wire

// File: rtl/ov7670_reg_rom.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// ov7670_reg_rom : register table, {addr, data} per entry, 1-cycle read latency
// Revision       : 1.0
// ----------------------------------------------------------------------------
module ov7670_reg_rom
  import ov7670_pkg::*;
#(
  parameter int NUM_REGS = 64,
  parameter int VARIANT  = 0
) (
  input  wire logic                        clk,
  input  wire logic [$clog2(NUM_REGS)-1:0] index,
  output logic      [ENTRY_W-1:0]          entry
);

  logic [ENTRY_W-1:0] w_entry;

  // Unlisted slots are zero-length delay entries, so they cost no SCCB traffic.
  always_comb begin
    w_entry = {DELAY_MARKER, 8'h00};
    if (VARIANT == 1) begin
      case (int'(index))
        0:       w_entry = {COM7_ADDR, 8'h80};
        1:       w_entry = {DELAY_MARKER, 8'h02};
        2:       w_entry = 16'h40D0;
        default: w_entry = {DELAY_MARKER, 8'h00};
      endcase
    end else begin
      case (int'(index))
        0:       w_entry = {COM7_ADDR, 8'h80};
        1:       w_entry = {DELAY_MARKER, 8'h0A};
        2:       w_entry = {COM7_ADDR, 8'h04};
        3:       w_entry = 16'h1101;
        4:       w_entry = 16'h0C00;
        5:       w_entry = 16'h3E00;
        6:       w_entry = 16'h40D0;
        7:       w_entry = 16'h8C00;
        8:       w_entry = 16'h3A04;
        9:       w_entry = 16'h1418;
        10:      w_entry = 16'h1713;
        11:      w_entry = 16'h1801;
        12:      w_entry = 16'h32B6;
        13:      w_entry = 16'h1902;
        14:      w_entry = 16'h1A7A;
        15:      w_entry = 16'h030A;
        default: w_entry = {DELAY_MARKER, 8'h00};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    entry <= w_entry;
  end

endmodule
`default_nettype wire

// File: rtl/ov7670_config_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// ov7670_config_sequencer : camera reset/boot, register table walk over SCCB,
//                           then arms pixel capture
// Revision                : 1.0
// ----------------------------------------------------------------------------
module ov7670_config_sequencer
  import ov7670_pkg::*;
#(
  parameter logic [7:0] SCCB_ID           = OV7670_WRITE_ID,
  parameter int         NUM_REGS          = 64,
  parameter int         RESET_HOLD_CYCLES = 25000,
  parameter int         BOOT_CYCLES       = 75000,
  parameter int         DELAY_UNIT        = 25000,
  parameter int         SETTLE_CYCLES     = 250000,
  parameter int         MAX_RETRIES       = 3,
  parameter int         TABLE_VARIANT     = 0
) (
  input  wire logic                           clk,
  input  wire logic                           reset_n,
  input  wire logic                           restart,
  ov7670_config_sequencer_if.master           sccb,
  output logic                                ov7670_reset,
  output logic                                ov7670_pwrdn,
  output logic                                start_capture,
  output logic                                busy,
  output logic                                error,
  output logic      [$clog2(NUM_REGS)-1:0]    err_index
);

  localparam int c_idx_w   = $clog2(NUM_REGS);
  localparam int c_cnt_w   = max_int(20, max_int(8 + $clog2(DELAY_UNIT + 1),
                             max_int($clog2(SETTLE_CYCLES + 1),
                             max_int($clog2(BOOT_CYCLES + 1), $clog2(RESET_HOLD_CYCLES + 1)))));
  localparam int c_retry_w = max_int(1, $clog2(MAX_RETRIES + 1));

  localparam logic [c_idx_w-1:0]   c_last_idx    = c_idx_w'(NUM_REGS - 1);
  localparam logic [c_cnt_w-1:0]   c_hold_last   = c_cnt_w'(RESET_HOLD_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]   c_boot_last   = c_cnt_w'(BOOT_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]   c_settle_last = c_cnt_w'(SETTLE_CYCLES - 1);
  localparam logic [c_cnt_w-1:0]   c_delay_unit  = c_cnt_w'(DELAY_UNIT);
  localparam logic [c_retry_w-1:0] c_retry_last  = c_retry_w'(MAX_RETRIES);

  seq_state_t           r_state;
  logic [c_idx_w-1:0]   r_index;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_retry_w-1:0] r_retries;
  logic                 r_req;
  logic [7:0]           r_addr;
  logic [7:0]           r_data;

  logic [ENTRY_W-1:0]   w_entry;
  logic [7:0]           w_entry_addr;
  logic [7:0]           w_entry_data;
  logic [c_cnt_w-1:0]   w_delay_load;

  ov7670_reg_rom #(
    .NUM_REGS (NUM_REGS),
    .VARIANT  (TABLE_VARIANT)
  ) u_rom (
    .clk   (clk),
    .index (r_index),
    .entry (w_entry)
  );

  assign w_entry_addr = w_entry[ENTRY_ADDR_LSB +: 8];
  assign w_entry_data = w_entry[ENTRY_DATA_LSB +: 8];
  // Counter is wide enough that the full 8-bit x DELAY_UNIT product never truncates.
  assign w_delay_load = c_cnt_w'(w_entry_data) * c_delay_unit;

  assign sccb.req  = r_req;
  assign sccb.id   = SCCB_ID;
  assign sccb.addr = r_addr;
  assign sccb.data = r_data;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_RST_HOLD;
      r_index       <= '0;
      r_cnt         <= '0;
      r_retries     <= '0;
      r_req         <= 1'b0;
      r_addr        <= 8'h00;
      r_data        <= 8'h00;
      ov7670_reset  <= 1'b0;
      ov7670_pwrdn  <= 1'b0;
      start_capture <= 1'b0;
      busy          <= 1'b1;
      error         <= 1'b0;
      err_index     <= '0;
    end else begin
      ov7670_pwrdn <= 1'b0;
      case (r_state)
        S_RST_HOLD: begin
          ov7670_reset <= 1'b0;
          if (r_cnt == c_hold_last) begin
            r_cnt        <= '0;
            ov7670_reset <= 1'b1;
            r_state      <= S_BOOT;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_BOOT: begin
          if (r_cnt == c_boot_last) begin
            r_cnt   <= '0;
            r_state <= S_FETCH;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          if (w_entry_addr == DELAY_MARKER) begin
            r_cnt   <= w_delay_load;
            r_state <= S_DELAY;
          end else begin
            r_addr  <= w_entry_addr;
            r_data  <= w_entry_data;
            r_req   <= 1'b1;
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          // nack has priority so a simultaneous ack/nack is retried
          if (sccb.nack) begin
            r_req <= 1'b0;
            if (r_retries == c_retry_last) begin
              err_index <= r_index;
              error     <= 1'b1;
              busy      <= 1'b0;
              r_state   <= S_ERROR;
            end else begin
              r_retries <= r_retries + 1'b1;
              r_state   <= S_REISSUE;
            end
          end else if (sccb.ack) begin
            r_req     <= 1'b0;
            r_retries <= '0;
            r_state   <= S_NEXT;
          end
        end
        S_REISSUE: begin
          r_req   <= 1'b1;
          r_state <= S_WAIT;
        end
        S_DELAY: begin
          if (r_cnt == '0) begin
            r_state <= S_NEXT;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_NEXT: begin
          if (r_index == c_last_idx) begin
            r_cnt   <= '0;
            r_state <= S_SETTLE;
          end else begin
            r_index <= r_index + 1'b1;
            r_state <= S_FETCH;
          end
        end
        S_SETTLE: begin
          if (r_cnt == c_settle_last) begin
            start_capture <= 1'b1;
            busy          <= 1'b0;
            r_state       <= S_DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE: begin
          // Re-walk the table only; the camera keeps its power-on state.
          if (restart) begin
            start_capture <= 1'b0;
            busy          <= 1'b1;
            r_index       <= '0;
            r_state       <= S_FETCH;
          end
        end
        S_ERROR: begin
          if (restart) begin
            error        <= 1'b0;
            err_index    <= '0;
            busy         <= 1'b1;
            r_index      <= '0;
            r_cnt        <= '0;
            r_retries    <= '0;
            ov7670_reset <= 1'b0;
            r_state      <= S_RST_HOLD;
          end
        end
        default: r_state <= S_RST_HOLD;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ov7670_config_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ov7670_config_sequencer : directed bench on the three-entry test table
// Revision                   : 1.0
// ----------------------------------------------------------------------------
module tb_ov7670_config_sequencer;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic       restart = 1'b0;
  logic       ov_rst;
  logic       ov_pwrdn;
  logic       start_cap;
  logic       busy;
  logic       err;
  logic [1:0] err_idx;
  int         n_vec  = 0;
  int         n_miss = 0;
  int         n;

  ov7670_config_sequencer_if sccb_bus ();

  ov7670_config_sequencer #(
    .SCCB_ID           (8'h42),
    .NUM_REGS          (3),
    .RESET_HOLD_CYCLES (4),
    .BOOT_CYCLES       (8),
    .DELAY_UNIT        (10),
    .SETTLE_CYCLES     (5),
    .MAX_RETRIES       (2),
    .TABLE_VARIANT     (1)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .restart       (restart),
    .sccb          (sccb_bus),
    .ov7670_reset  (ov_rst),
    .ov7670_pwrdn  (ov_pwrdn),
    .start_capture (start_cap),
    .busy          (busy),
    .error         (err),
    .err_index     (err_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ack_pulse();
    sccb_bus.ack = 1'b1;
    tick();
    sccb_bus.ack = 1'b0;
  endtask

  task automatic nack_pulse();
    sccb_bus.nack = 1'b1;
    tick();
    sccb_bus.nack = 1'b0;
  endtask

  task automatic restart_pulse();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  // sel 0 waits for sccb req, sel 1 for start_capture; returns edges elapsed
  task automatic wait_for(input int sel, input int bound, output int cnt);
    cnt = 0;
    do begin
      tick();
      cnt++;
    end while ((((sel == 0) ? sccb_bus.req : start_cap) !== 1'b1) && (cnt < bound));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ov_rst"},  {31'd0, ov_rst},        32'd0);
    check({tag, "_pwrdn"},   {31'd0, ov_pwrdn},      32'd0);
    check({tag, "_req"},     {31'd0, sccb_bus.req},  32'd0);
    check({tag, "_addr"},    {24'd0, sccb_bus.addr}, 32'd0);
    check({tag, "_data"},    {24'd0, sccb_bus.data}, 32'd0);
    check({tag, "_start"},   {31'd0, start_cap},     32'd0);
    check({tag, "_busy"},    {31'd0, busy},          32'd1);
    check({tag, "_error"},   {31'd0, err},           32'd0);
    check({tag, "_err_idx"}, {30'd0, err_idx},       32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    sccb_bus.ack  = 1'b0;
    sccb_bus.nack = 1'b0;

    // Power-on reset values
    repeat (2) tick();
    check_reset_values("por");
    check("por_id", {24'd0, sccb_bus.id}, 32'h42);

    // Camera reset held for 4 edges after release
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) tick();
    check("hold_low", {31'd0, ov_rst}, 32'd0);
    tick();
    check("hold_release", {31'd0, ov_rst}, 32'd1);

    // 8 boot cycles + FETCH + DECODE before the first request
    wait_for(0, 40, n);
    check("first_req_lat", n, 32'd10);
    check("w0_addr", {24'd0, sccb_bus.addr}, 32'h12);
    check("w0_data", {24'd0, sccb_bus.data}, 32'h80);
    check("w0_id",   {24'd0, sccb_bus.id},   32'h42);
    check("w0_busy", {31'd0, busy},          32'd1);
    repeat (3) tick();
    check("w0_req_held", {31'd0, sccb_bus.req}, 32'd1);
    ack_pulse();
    check("w0_req_drop", {31'd0, sccb_bus.req}, 32'd0);

    // Delay entry 2*10: NEXT, FETCH, DECODE, 21 DELAY, NEXT, FETCH, DECODE
    wait_for(0, 60, n);
    check("w2_req_lat", n, 32'd27);
    check("w2_addr", {24'd0, sccb_bus.addr}, 32'h40);
    check("w2_data", {24'd0, sccb_bus.data}, 32'hD0);

    // Two NACKs, each followed by a one-cycle req gap and a re-issue
    repeat (3) tick();
    nack_pulse();
    check("nack1_req_drop", {31'd0, sccb_bus.req}, 32'd0);
    tick();
    check("reissue1_req",  {31'd0, sccb_bus.req},  32'd1);
    check("reissue1_addr", {24'd0, sccb_bus.addr}, 32'h40);
    check("reissue1_data", {24'd0, sccb_bus.data}, 32'hD0);
    nack_pulse();
    check("nack2_req_drop", {31'd0, sccb_bus.req}, 32'd0);
    tick();
    check("reissue2_req",  {31'd0, sccb_bus.req},  32'd1);
    check("reissue2_addr", {24'd0, sccb_bus.addr}, 32'h40);
    ack_pulse();

    // Restart during SETTLE is ignored; start_capture 6 edges after ack
    tick();
    restart_pulse();
    check("settle_restart_busy", {31'd0, busy}, 32'd1);
    wait_for(1, 20, n);
    check("start_lat", n, 32'd4);
    check("done_busy",  {31'd0, busy},         32'd0);
    check("done_error", {31'd0, err},          32'd0);
    check("done_req",   {31'd0, sccb_bus.req}, 32'd0);

    // Restart from DONE re-walks without a camera reset
    restart_pulse();
    check("rerun_start", {31'd0, start_cap}, 32'd0);
    check("rerun_busy",  {31'd0, busy},      32'd1);
    wait_for(0, 20, n);
    check("rerun_req_lat", n, 32'd2);
    check("rerun_ov_rst",  {31'd0, ov_rst},        32'd1);
    check("rerun_addr",    {24'd0, sccb_bus.addr}, 32'h12);
    ack_pulse();
    wait_for(0, 60, n);
    check("rerun_w2_lat", n, 32'd27);

    // Three NACKs exhaust the retries on entry 2
    nack_pulse();
    tick();
    nack_pulse();
    tick();
    nack_pulse();
    check("err_flag",  {31'd0, err},          32'd1);
    check("err_index", {30'd0, err_idx},      32'd2);
    check("err_start", {31'd0, start_cap},    32'd0);
    check("err_busy",  {31'd0, busy},         32'd0);
    check("err_req",   {31'd0, sccb_bus.req}, 32'd0);
    repeat (5) tick();
    check("err_no_req", {31'd0, sccb_bus.req}, 32'd0);

    // Restart from ERROR performs a full camera reset
    restart_pulse();
    check("errrst_error",   {31'd0, err},     32'd0);
    check("errrst_err_idx", {30'd0, err_idx}, 32'd0);
    check("errrst_ov_rst",  {31'd0, ov_rst},  32'd0);
    repeat (3) tick();
    check("errrst_hold_low", {31'd0, ov_rst}, 32'd0);
    tick();
    check("errrst_release", {31'd0, ov_rst}, 32'd1);
    wait_for(0, 40, n);
    check("errrst_req_lat", n, 32'd10);

    // Asynchronous reset mid-WAIT takes effect before the next edge
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_values("async");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
